dircc_processing_mem_port_arbiter: RTL and testbench
====================================================

// Module: dircc_processing_mem_port_arbiter
// PURPOSE
//  Shares the 16-bit second port (s2) of a node's dual-port processing memory between NUM_REQ
//  Avalon-MM masters (mailbox RX writer, TX reader, debug). Round-robin grant with optional lock
//  and bounded hold, 1-cycle read latency, readdatavalid routed back to the owning requester.
// PARAMETERS
//  NUM_REQ   2   number of requesting masters (2..4)
//  ADDR_W    14  s2 address width (16-bit words)
//  DATA_W    16  s2 data width
//  BE_W      2   byteenable width (DATA_W/8)
//  MAX_LOCK  16  max consecutive grants to a locked owner before forced rotation (>=1)
// PORTS
//  clk             in   1                 clock (same clock as the memory)
//  reset_n         in   1                 asynchronous active-low reset
//  req_read        in   NUM_REQ           per-requester read strobe
//  req_write       in   NUM_REQ           per-requester write strobe
//  req_lock        in   NUM_REQ           hold grant across back-to-back transfers
//  req_address     in   NUM_REQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_byteenable  in   NUM_REQ*BE_W      packed byteenables
//  req_writedata   in   NUM_REQ*DATA_W    packed write data
//  req_waitrequest out  NUM_REQ           1 = command not accepted this cycle
//  req_readdata    out  DATA_W            shared read data, qualify with req_readdatavalid
//  req_readdatavalid out NUM_REQ          one-hot, read data for requester i
//  mem_address2    out  ADDR_W            to memory address2
//  mem_byteenable2 out  BE_W              to memory byteenable2
//  mem_chipselect2 out  1                 to memory chipselect2
//  mem_write2      out  1                 to memory write2
//  mem_writedata2  out  DATA_W            to memory writedata2
//  mem_clken2      out  1                 to memory clken2, tied 1
//  mem_readdata2   in   DATA_W            from memory readdata2
// BEHAVIOUR
//  - Reset: req_waitrequest all 1 combinationally only when no grant; regs: rr_ptr=0, owner=none,
//    lock_cnt=0, rd_pending=0, rd_owner=0; req_readdatavalid=0; mem_chipselect2=0, mem_write2=0.
//  - Request i active = req_read[i]|req_write[i]. Each cycle exactly one active requester is granted:
//    if a locked owner exists, is still active with req_lock=1 and lock_cnt<MAX_LOCK -> owner;
//    else first active index at or after rr_ptr (wrapping NUM_REQ-1 -> 0).
//  - Granted command goes to memory combinationally same cycle: chipselect2=1, write2=req_write,
//    address/byteenable/writedata muxed; req_waitrequest[g]=0, all others 1. No request -> cs2=0.
//  - Accepted command: rr_ptr <= g+1 (wrap). If req_lock[g]: owner<=g, lock_cnt<=lock_cnt+1 when
//    g==owner else 1. Otherwise owner<=none, lock_cnt<=0.
//  - lock_cnt reaching MAX_LOCK: owner ignored for one arbitration, normal RR applies; if the
//    owner wins again lock_cnt restarts at 1. Guarantees every active requester served within
//    NUM_REQ*MAX_LOCK cycles.
//  - Read latency: accepted read at cycle N -> req_readdatavalid[g]=1 at cycle N+1 with
//    req_readdata=mem_readdata2 (memory registers address, output unregistered). Pipelined:
//    back-to-back reads from any mix of requesters, one valid per cycle, in acceptance order.
//  - Writes: complete on acceptance, no response. req_read&req_write both set on one requester is
//    a protocol error; treated as write, no readdatavalid generated.
//  - Write then read same address next cycle returns new data (memory port-B same-port behaviour).
//  - Requester dropping request while waitrequest=1 is allowed; no state is recorded.
//  - reset_n asserted mid-read: pending readdatavalid is dropped, never emitted after release.
//  - No throughput loss: memory port issues one command every cycle while any request is active.
// STRUCTURE
//  - Package dircc_mem_arb_pkg: ARB_NONE owner encoding, default widths, MAX_LOCK default,
//    function for packed-slice extraction.
//  - Sub-module dircc_rr_pick: combinational round-robin picker (req vector, ptr -> one-hot grant,
//    index, any). Top holds owner/lock counter/read-pending registers and muxes.
// TESTING
//  - Single req0 read addr 0x0010, mem word 0xBEEF -> ws[0]=0 same cycle, rdv[0]=1 next cycle, data 0xBEEF.
//  - req0 and req1 continuous reads, no lock -> grants alternate 0,1,0,1; rdv one-hot follows 1 cycle later.
//  - req0 locked writes continuous, req1 reading, MAX_LOCK=4 -> 4 grants to 0, then 1 grant to 1, repeat.
//  - req1 write 0x1234 addr 0x3FFF BE=2'b10 then read -> readback 0x12xx, low byte unchanged.
//  - Read accepted, reset_n low next cycle -> no rdv after reset; first post-reset grant goes to req0.
//  - rr_ptr=NUM_REQ-1, only req0 active -> req0 granted immediately (wrap), rr_ptr returns to 1.

Source files
------------

// File: rtl/dircc_mem_arb_pkg.sv
// Shared types, widths and helpers for the
// processing-memory port-2 arbiter.
package dircc_mem_arb_pkg;

  localparam int IDX_W = 2;
  localparam int OWN_W = 3;
  localparam logic [OWN_W-1:0] ARB_NONE = '1;

  localparam int DEF_NUM_REQ  = 2;
  localparam int DEF_ADDR_W   = 14;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_BE_W     = 2;
  localparam int DEF_MAX_LOCK = 16;

  localparam int SLICE_W = 64;

  function automatic logic [SLICE_W-1:0] slice(
    input logic [SLICE_W-1:0] vec,
    input int                 idx,
    input int                 w
  );
    return vec >> (idx * w);
  endfunction

endpackage

// File: rtl/dircc_processing_mem_port_arbiter_if.sv
// Requester-side Avalon-MM bundle, packed per requester.
// master: requesters drive commands; slave: arbiter answers.
interface dircc_processing_mem_port_arbiter_if
  import dircc_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BE_W    = DEF_BE_W
) ();

  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*BE_W-1:0]   req_byteenable;
  logic [NUM_REQ*DATA_W-1:0] req_writedata;
  logic [NUM_REQ-1:0]        req_waitrequest;
  logic [DATA_W-1:0]         req_readdata;
  logic [NUM_REQ-1:0]        req_readdatavalid;

  modport master (
    output req_read, req_write, req_lock,
    output req_address, req_byteenable,
    output req_writedata,
    input  req_waitrequest, req_readdata,
    input  req_readdatavalid
  );

  modport slave (
    input  req_read, req_write, req_lock,
    input  req_address, req_byteenable,
    input  req_writedata,
    output req_waitrequest, req_readdata,
    output req_readdatavalid
  );

endinterface

// File: rtl/dircc_rr_pick.sv
// Combinational round-robin picker: first set bit of req
// at or after ptr, wrapping. Ports: req, ptr -> grant, idx, any.
module dircc_rr_pick
  import dircc_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    // Scan backwards so the nearest index wins last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        idx = IDX_W'(j);
        any = 1'b1;
      end
    end
    grant = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/dircc_processing_mem_port_arbiter.sv
// Shares memory port 2 among NUM_REQ Avalon-MM masters:
// round-robin with bounded lock, 1-cycle routed read data.
// Ports: clk, reset_n, bus (slave requester bundle),
// mem_* command outputs, mem_readdata2 input.
module dircc_processing_mem_port_arbiter
  import dircc_mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BE_W     = DEF_BE_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              clk,
  input  logic              reset_n,
  dircc_processing_mem_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] mem_address2,
  output logic [BE_W-1:0]   mem_byteenable2,
  output logic              mem_chipselect2,
  output logic              mem_write2,
  output logic [DATA_W-1:0] mem_writedata2,
  output logic              mem_clken2,
  input  logic [DATA_W-1:0] mem_readdata2
);

  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_MAX =
    LCW'(MAX_LOCK);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   rr_ptr;
  logic [OWN_W-1:0]   owner;
  logic [LCW-1:0]     lock_cnt;
  logic               rd_pending;
  logic [IDX_W-1:0]   rd_owner;

  logic [3:0]         act;
  logic [3:0]         lck;
  logic [3:0]         wr;
  logic [IDX_W-1:0]   own_idx;
  logic [NUM_REQ-1:0] rr_grant;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   g;
  logic               any;
  logic               use_owner;

  // Padded to 4 so a 2-bit index is always in range.
  assign act = 4'(bus.req_read | bus.req_write);
  assign lck = 4'(bus.req_lock);
  assign wr  = 4'(bus.req_write);

  assign own_idx = owner[IDX_W-1:0];

  // Owner keeps the port until it drops lock or
  // exhausts its MAX_LOCK budget.
  assign use_owner = (owner != ARB_NONE)
                   && act[own_idx]
                   && lck[own_idx]
                   && (lock_cnt < LOCK_MAX);

  dircc_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req   (act[NUM_REQ-1:0]),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (any)
  );

  assign g     = use_owner ? own_idx : rr_idx;
  assign grant = use_owner
               ? (NUM_REQ'(1) << own_idx)
               : rr_grant;

  assign mem_chipselect2 = any;
  assign mem_write2      = any & wr[g];
  assign mem_clken2      = 1'b1;
  assign mem_address2    = ADDR_W'(slice(
    SLICE_W'(bus.req_address), int'(g), ADDR_W));
  assign mem_byteenable2 = BE_W'(slice(
    SLICE_W'(bus.req_byteenable), int'(g), BE_W));
  assign mem_writedata2  = DATA_W'(slice(
    SLICE_W'(bus.req_writedata), int'(g), DATA_W));

  assign bus.req_waitrequest   = ~grant;
  assign bus.req_readdata      = mem_readdata2;
  assign bus.req_readdatavalid = rd_pending
                               ? (NUM_REQ'(1) << rd_owner)
                               : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      owner      <= ARB_NONE;
      lock_cnt   <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= '0;
    end else begin
      // Read+write together counts as a write.
      rd_pending <= any & ~wr[g];
      rd_owner   <= g;
      if (any) begin
        rr_ptr <= (g == LAST) ? '0 : g + 1'b1;
        if (lck[g]) begin
          owner    <= OWN_W'(g);
          lock_cnt <= use_owner
                    ? lock_cnt + 1'b1
                    : LCW'(1);
        end else begin
          owner    <= ARB_NONE;
          lock_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dircc_processing_mem_port_arbiter.sv
// Self-checking bench for the port-2 arbiter with a
// requester-level reference model and a memory model.
module tb_dircc_processing_mem_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int ML = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  dircc_processing_mem_port_arbiter_if #(
    .NUM_REQ(NR), .ADDR_W(AW),
    .DATA_W(DW), .BE_W(BW)
  ) bus ();

  logic [AW-1:0] mem_address2;
  logic [BW-1:0] mem_byteenable2;
  logic          mem_chipselect2;
  logic          mem_write2;
  logic [DW-1:0] mem_writedata2;
  logic          mem_clken2;
  logic [DW-1:0] mem_readdata2;

  dircc_processing_mem_port_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW),
    .BE_W(BW), .MAX_LOCK(ML)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .mem_address2    (mem_address2),
    .mem_byteenable2 (mem_byteenable2),
    .mem_chipselect2 (mem_chipselect2),
    .mem_write2      (mem_write2),
    .mem_writedata2  (mem_writedata2),
    .mem_clken2      (mem_clken2),
    .mem_readdata2   (mem_readdata2)
  );

  always #5 clk = ~clk;

  // Memory: registered address, unregistered output.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] mem_aq = '0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a = '0;
  logic [DW-1:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (mem_chipselect2 && mem_clken2) begin
      if (mem_write2 && mem_byteenable2[0])
        mem[mem_address2][7:0] <= mem_writedata2[7:0];
      if (mem_write2 && mem_byteenable2[1])
        mem[mem_address2][15:8] <= mem_writedata2[15:8];
      mem_aq <= mem_address2;
    end
  end

  assign mem_readdata2 = mem[mem_aq];

  int total = 0;
  int bad = 0;

  logic [NR-1:0] rd, wr, lk;
  logic [AW-1:0] ad [NR];
  logic [BW-1:0] be [NR];
  logic [DW-1:0] wd [NR];

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int m_ptr, m_owner, m_cnt;
  bit pv;
  int pg;
  logic [DW-1:0] pd;

  int dir_g = -2;
  logic [NR-1:0] obs_rdv;
  logic [DW-1:0] obs_data;

  task automatic m_reset();
    m_ptr = 0;
    m_owner = -1;
    m_cnt = 0;
    pv = 1'b0;
  endtask

  function automatic int pick(input logic [NR-1:0] a);
    if (m_owner >= 0 && a[m_owner] && lk[m_owner]
        && m_cnt < ML)
      return m_owner;
    for (int k = 0; k < NR; k++)
      if (a[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  task automatic clear();
    rd = '0;
    wr = '0;
    lk = '0;
    for (int i = 0; i < NR; i++) begin
      ad[i] = '0;
      be[i] = '0;
      wd[i] = '0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_address[i*AW +: AW] = ad[i];
      bus.req_byteenable[i*BW +: BW] = be[i];
      bus.req_writedata[i*DW +: DW] = wd[i];
    end
    bus.req_read = rd;
    bus.req_write = wr;
    bus.req_lock = lk;
  endtask

  // One clock: drive at negedge, check, advance model.
  task automatic cycle();
    logic [NR-1:0] exp_ws, exp_rdv;
    int g;
    drive();
    #1;
    g = pick(rd | wr);
    exp_ws = '1;
    if (g >= 0) exp_ws[g] = 1'b0;
    total++;
    if (bus.req_waitrequest !== exp_ws) begin
      bad++;
      $display("FAIL waitrequest: got %b want %b",
               bus.req_waitrequest, exp_ws);
    end
    total++;
    if (g >= 0) begin
      if ({mem_chipselect2, mem_write2, mem_address2}
          !== {1'b1, wr[g], ad[g]}) begin
        bad++;
        $display("FAIL mem_cmd: got %b/%b/%h want 1/%b/%h",
                 mem_chipselect2, mem_write2,
                 mem_address2, wr[g], ad[g]);
      end
      if (wr[g]) begin
        total++;
        if ({mem_byteenable2, mem_writedata2}
            !== {be[g], wd[g]}) begin
          bad++;
          $display("FAIL mem_wdata: got %b/%h want %b/%h",
                   mem_byteenable2, mem_writedata2,
                   be[g], wd[g]);
        end
      end
    end else if (mem_chipselect2 !== 1'b0) begin
      bad++;
      $display("FAIL idle_cs: got %b want 0",
               mem_chipselect2);
    end
    exp_rdv = pv ? (NR'(1) << pg) : '0;
    obs_rdv = bus.req_readdatavalid;
    obs_data = bus.req_readdata;
    total++;
    if (obs_rdv !== exp_rdv) begin
      bad++;
      $display("FAIL rdv: got %b want %b",
               obs_rdv, exp_rdv);
    end
    if (pv) begin
      total++;
      if (obs_data !== pd) begin
        bad++;
        $display("FAIL rdata: got %h want %h",
                 obs_data, pd);
      end
    end
    if (dir_g != -2) begin
      exp_ws = '1;
      if (dir_g >= 0) exp_ws[dir_g] = 1'b0;
      total++;
      if (bus.req_waitrequest !== exp_ws) begin
        bad++;
        $display("FAIL directed_grant: got %b want %b",
                 bus.req_waitrequest, exp_ws);
      end
      dir_g = -2;
    end
    @(posedge clk);
    pv = 1'b0;
    if (g >= 0) begin
      m_ptr = (g + 1) % NR;
      if (lk[g]) begin
        m_cnt = (m_owner == g && m_cnt < ML)
              ? m_cnt + 1 : 1;
        m_owner = g;
      end else begin
        m_owner = -1;
        m_cnt = 0;
      end
      if (wr[g]) begin
        if (be[g][0]) ref_mem[ad[g]][7:0] = wd[g][7:0];
        if (be[g][1]) ref_mem[ad[g]][15:8] = wd[g][15:8];
      end else begin
        pv = 1'b1;
        pg = g;
        pd = ref_mem[ad[g]];
      end
    end
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    pl_en = 1'b1;
    pl_a = a;
    pl_d = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear();
    drive();
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      preload(AW'(i), DW'($urandom));
    preload(14'h0010, 16'hBEEF);
    preload(14'h3FFF, 16'h5AC3);
    total++;
    if (bus.req_waitrequest !== 3'b111) begin
      bad++;
      $display("FAIL reset_ws: got %b want 111",
               bus.req_waitrequest);
    end
    total++;
    if (bus.req_readdatavalid !== 3'b000) begin
      bad++;
      $display("FAIL reset_rdv: got %b want 000",
               bus.req_readdatavalid);
    end
    total++;
    if ({mem_chipselect2, mem_write2} !== 2'b00) begin
      bad++;
      $display("FAIL reset_cs_we: got %b want 00",
               {mem_chipselect2, mem_write2});
    end
    total++;
    if (mem_clken2 !== 1'b1) begin
      bad++;
      $display("FAIL clken: got %b want 1", mem_clken2);
    end
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_single_read();
    clear();
    rd[0] = 1'b1;
    ad[0] = 14'h0010;
    dir_g = 0;
    cycle();
    clear();
    cycle();
    total++;
    if (obs_rdv !== 3'b001 || obs_data !== 16'hBEEF) begin
      bad++;
      $display("FAIL single_read: got %b/%h want 001/beef",
               obs_rdv, obs_data);
    end
  endtask

  task automatic test_alternate();
    clear();
    rd[2] = 1'b1;
    dir_g = 2;
    cycle();
    for (int i = 0; i < 6; i++) begin
      clear();
      rd = 3'b011;
      ad[0] = AW'($urandom_range(0, 15));
      ad[1] = AW'($urandom_range(0, 15));
      dir_g = i % 2;
      cycle();
      if (i > 0) begin
        total++;
        if (obs_rdv !== (NR'(1) << ((i - 1) % 2))) begin
          bad++;
          $display("FAIL alt_rdv: got %b step %0d",
                   obs_rdv, i);
        end
      end
    end
    clear();
    cycle();
  endtask

  task automatic test_lock();
    clear();
    rd[2] = 1'b1;
    dir_g = 2;
    cycle();
    for (int i = 0; i < 10; i++) begin
      clear();
      wr[0] = 1'b1;
      lk[0] = 1'b1;
      ad[0] = AW'($urandom_range(0, 15));
      be[0] = 2'b11;
      wd[0] = DW'($urandom);
      rd[1] = 1'b1;
      ad[1] = AW'($urandom_range(0, 15));
      dir_g = (i % 5 == 4) ? 1 : 0;
      cycle();
    end
    clear();
    cycle();
  endtask

  task automatic test_byteenable();
    logic [7:0] lo;
    lo = ref_mem[14'h3FFF][7:0];
    clear();
    wr[1] = 1'b1;
    ad[1] = 14'h3FFF;
    be[1] = 2'b10;
    wd[1] = 16'h1234;
    cycle();
    clear();
    rd[1] = 1'b1;
    ad[1] = 14'h3FFF;
    cycle();
    clear();
    cycle();
    total++;
    if (obs_rdv !== 3'b010 || obs_data !== {8'h12, lo}) begin
      bad++;
      $display("FAIL be_readback: got %b/%h want 010/12%h",
               obs_rdv, obs_data, lo);
    end
  endtask

  task automatic test_wrap();
    clear();
    rd[1] = 1'b1;
    dir_g = 1;
    cycle();
    clear();
    rd[0] = 1'b1;
    dir_g = 0;
    cycle();
    clear();
    rd = 3'b111;
    dir_g = 1;
    cycle();
    clear();
    cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      clear();
      rd = 3'b111;
      for (int j = 0; j < NR; j++)
        ad[j] = AW'($urandom_range(0, 15));
      cycle();
    end
    clear();
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        int r;
        r = $urandom_range(0, 9);
        rd[i] = (r <= 3) || (r == 9);
        wr[i] = (r >= 4 && r <= 6) || (r == 9);
        lk[i] = ($urandom_range(0, 3) != 0);
        ad[i] = AW'($urandom_range(0, 15));
        be[i] = BW'($urandom_range(1, 3));
        wd[i] = DW'($urandom);
      end
      cycle();
    end
    clear();
    cycle();
  endtask

  task automatic test_reset_mid_read();
    clear();
    rd[0] = 1'b1;
    ad[0] = 14'h0005;
    cycle();
    clear();
    drive();
    #1;
    total++;
    if (bus.req_readdatavalid !== 3'b001) begin
      bad++;
      $display("FAIL pre_reset_rdv: got %b want 001",
               bus.req_readdatavalid);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    m_reset();
    #1;
    total++;
    if (bus.req_readdatavalid !== 3'b000) begin
      bad++;
      $display("FAIL in_reset_rdv: got %b want 000",
               bus.req_readdatavalid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_readdatavalid !== 3'b000) begin
      bad++;
      $display("FAIL post_reset_rdv: got %b want 000",
               bus.req_readdatavalid);
    end
    clear();
    rd = 3'b011;
    dir_g = 0;
    cycle();
    clear();
    cycle();
  endtask

  initial begin
    clear();
    drive();
    m_reset();
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_byteenable();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
